// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the accumulator/ALU stage
// and the control unit that drives it.
//   ALU_NOP..ALU_LSHIFT : 3-bit alu_op encodings (5..7 reserved, treated as NOP)
//   alu_state_t         : ALU FSM state (ST_IDLE, ST_MUL)
package alu_pkg;

    localparam logic [2:0] ALU_NOP    = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_MULT   = 3'd3;
    localparam logic [2:0] ALU_LSHIFT = 3'd4;

    typedef logic [0:0] alu_state_t;

    localparam alu_state_t ST_IDLE = 1'b0;
    localparam alu_state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: iterative shift-add multiplier, low WIDTH bits of the product.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               latch operands and begin (ignored while busy)
//   multiplicand        operand A (AC at issue time)
//   multiplier          operand B (R at issue time)
//   abort               cancel an in-flight multiply
//   product             final product; valid while done is high
//   busy                iteration in progress
//   done                high during the last iteration: the coming edge
//                       completes the multiply and product holds the result
module alu_mult_seq #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MULT_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             abort,
    output logic [WIDTH-1:0] product,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] partial_q;
    logic [WIDTH-1:0] partial_nxt;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             last;

    always_comb begin
        partial_nxt = partial_q;
        if (mplier_q[0]) begin
            partial_nxt = partial_q + mcand_q;
        end
    end

    // The final iteration's partial sum is handed out combinationally so the
    // caller can write it on the same edge that ends the iteration count.
    assign last    = (cnt_q == CW'(MULT_CYCLES - 1));
    assign product = partial_nxt;
    assign busy    = busy_q;
    assign done    = busy_q && last && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else if (abort) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (busy_q) begin
            partial_q <= partial_nxt;
            mcand_q   <= {mcand_q[WIDTH-2:0], 1'b0};
            mplier_q  <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q     <= last ? '0 : cnt_q + CW'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end else if (start) begin
            mcand_q   <= multiplicand;
            mplier_q  <= multiplier;
            partial_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: accumulator (AC) and ALU stage driven by the control unit.
// Optional feature macro: ALU_MULT_EN (iterative MULT; without it MULT is a
// NOP and busy/done are tied low).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   alu_op       NOP/ADD/SUB/MULT/LSHIFT (5..7 = NOP)
//   r_in         operand B (R register)
//   bus_in       shared bus, loaded into AC on ac_we
//   ac_we        AC <= bus_in
//   ac_inc       AC <= AC + 1
//   ac_clr       AC <= 0, also aborts a multiply
//   ac_out       AC register
//   z            registered AC == 0 flag
//   busy         multiply in progress
//   done         one-cycle pulse in the cycle the multiply result appears
module alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MULT_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ac_we,
    input  logic             ac_inc,
    input  logic             ac_clr,
    output logic [WIDTH-1:0] ac_out,
    output logic             z,
    output logic             busy,
    output logic             done
);

    if (MULT_CYCLES != WIDTH) begin : g_cfg_check
        $error("alu_unit: MULT_CYCLES must equal WIDTH");
    end

    logic [WIDTH-1:0] ac_q;
    logic [WIDTH-1:0] ac_nxt;
    logic             ac_wr;
    logic             z_q;

`ifdef ALU_MULT_EN
    alu_state_t       state_q;
    logic             mult_start;
    logic             seq_busy;
    logic             seq_done;
    logic [WIDTH-1:0] seq_product;
    logic             done_q;

    alu_mult_seq #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES)
    ) u_mult (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mult_start),
        .multiplicand (ac_q),
        .multiplier   (r_in),
        .abort        (ac_clr && (state_q == ST_MUL)),
        .product      (seq_product),
        .busy         (seq_busy),
        .done         (seq_done)
    );
`endif

    always_comb begin
        ac_wr  = 1'b0;
        ac_nxt = ac_q;
`ifdef ALU_MULT_EN
        mult_start = 1'b0;
        // While multiplying only ac_clr is honoured; all else is stalled.
        if (state_q == ST_MUL) begin
            if (ac_clr) begin
                ac_wr  = 1'b1;
                ac_nxt = '0;
            end else if (seq_done) begin
                ac_wr  = 1'b1;
                ac_nxt = seq_product;
            end
        end else begin
`else
        begin
`endif
            if (ac_clr) begin
                ac_wr  = 1'b1;
                ac_nxt = '0;
            end else if (ac_we) begin
                ac_wr  = 1'b1;
                ac_nxt = bus_in;
            end else if (ac_inc) begin
                ac_wr  = 1'b1;
                ac_nxt = ac_q + WIDTH'(1);
            end else begin
                case (alu_op)
                    ALU_ADD: begin
                        ac_wr  = 1'b1;
                        ac_nxt = ac_q + r_in;
                    end
                    ALU_SUB: begin
                        ac_wr  = 1'b1;
                        ac_nxt = ac_q - r_in;
                    end
                    ALU_LSHIFT: begin
                        ac_wr  = 1'b1;
                        ac_nxt = {ac_q[WIDTH-2:0], 1'b0};
                    end
`ifdef ALU_MULT_EN
                    ALU_MULT: mult_start = 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ac_q <= '0;
            z_q  <= 1'b1;
        end else if (ac_wr) begin
            ac_q <= ac_nxt;
            z_q  <= (ac_nxt == '0);
        end
    end

`ifdef ALU_MULT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == ST_MUL) && seq_done && !ac_clr;
            if (state_q == ST_IDLE) begin
                if (mult_start) begin
                    state_q <= ST_MUL;
                end
            end else if (ac_clr || seq_done) begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign busy = seq_busy;
    assign done = done_q;
`else
    assign busy = 1'b0;
    assign done = 1'b0;
`endif

    assign ac_out = ac_q;
    assign z      = z_q;

endmodule

// File: doc/alu_unit.md
# alu_unit

Accumulator-and-ALU stage driven directly by the processor control unit. Holds AC and consumes the control unit's `alu_op`, AC write/increment/clear strobes and the shared data bus. Produces AC and the zero flag that the control unit branches on (JPNZ/JMPZ). Multiplication is iterative shift-add with a `busy` stall output; all other operations complete in one cycle.

## Interface
- `WIDTH`, 16: data/AC width.
- `MULT_CYCLES`, 16: multiply iterations; always equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- `alu_op`  in  3  0 NOP, 1 ADD, 2 SUB, 3 MULT, 4 LSHIFT, 5–7 reserved (NOP).
- `r_in`  in  WIDTH  operand B, the R register value.
- `bus_in`  in  WIDTH  shared bus value, loaded into AC on `ac_we`.
- `ac_we`  in  1  load AC from `bus_in`.
- `ac_inc`  in  1  AC <= AC + 1.
- `ac_clr`  in  1  AC <= 0; aborts a multiply.
- `ac_out`  out  WIDTH  AC register.
- `z`  out  1  registered; 1 when AC == 0.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse when the multiply result is written.

## Operation
- Reset (`rst_n`=0 at an edge): AC=0, z=1, busy=0, done=0, iteration counter=0, FSM=IDLE. Reset wins over every other input, including mid-multiply.
- FSM states: IDLE and MUL.
- IDLE, priority per edge: `ac_clr` > `ac_we` > `ac_inc` > `alu_op`. Only the highest-priority active request takes effect.
  - ADD: AC <= AC + r_in, modulo 2^WIDTH, carry discarded.
  - SUB: AC <= AC − r_in, modulo 2^WIDTH.
  - LSHIFT: AC <= {AC[WIDTH-2:0], 1'b0}.
  - MULT: latch multiplicand=AC and multiplier=r_in, clear the partial product and counter, go to MUL. AC is unchanged during MUL.
- MUL: each edge, if multiplier[0] then partial += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After `MULT_CYCLES` iterations: AC <= partial[WIDTH-1:0] (low half, overflow discarded), done=1 for one cycle, return to IDLE.
- In MUL:
  - `alu_op`, `ac_we` and `ac_inc` are ignored; the control unit must stall on `busy`.
  - `ac_clr` aborts: AC=0, z=1, busy=0, done=0, FSM=IDLE.
- `z` updates on the same edge as every AC write: z <= (next AC == 0). During MUL, z keeps its pre-multiply value.
- Wrap-around: 0xFFFF+1 → 0x0000 with z=1. 0x0000−1 → 0xFFFF with z=0.

## Timing
- Single-cycle ops and strobes: sampled at edge T, result on `ac_out`/`z` in cycle T+1.
- MULT sampled at edge T0:
  - `busy`=1 from cycle T0+1 through T0+16.
  - Result and `z` visible from cycle T0+17, with `done`=1 in that cycle only and `busy`=0.
- A new op presented in the `done` cycle is accepted, giving back-to-back operation.
- `alu_op` is level-sampled every IDLE cycle. The control unit holds a non-NOP opcode for exactly one cycle per instruction.

## Configuration
- `ALU_MULT_EN` defined: MULT is implemented as above.
- `ALU_MULT_EN` undefined:
  - MULT decodes as NOP; AC is unchanged.
  - `busy` and `done` are tied to 0.
  - The MUL state, counter and operand registers are not built.

## Structure
- Shared package `alu_pkg`: opcode constants `ALU_NOP`=0, `ALU_ADD`=1, `ALU_SUB`=2, `ALU_MULT`=3, `ALU_LSHIFT`=4, and an FSM state type. The control unit imports the same opcodes.
- One sub-module, `alu_mult_seq`: the shift-add iterator.
  - Inputs: start, operands, abort.
  - Outputs: product, busy, done.
  - Instantiated only under `ALU_MULT_EN`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs → AC=0, z=1, busy=0, done=0.
- ADD wrap: `ac_we` with bus=0xFFFE, then ADD with r_in=0x0002 → AC=0x0000, z=1 one cycle after the ADD.
- SUB/LSHIFT: AC=0x0005; SUB r_in=0x0006 → 0xFFFF, z=0; then LSHIFT → 0xFFFE.
- MULT: AC=0x0123, r_in=0x0045, MULT → busy for 16 cycles, then AC=0x4E6F and done for 1 cycle. Also AC=0x8000 × 0x0002 → AC=0x0000, z=1.
- Abort and priority:
  - `ac_clr` in cycle 8 of a multiply → AC=0, busy=0, no done.
  - `ac_we` and ADD in the same IDLE cycle → bus value loaded, ADD dropped.
- Config: build without `ALU_MULT_EN`, issue MULT on AC=0x0007 → AC stays 0x0007, busy never asserts.
